rx_serial_7e1: RTL and testbench

- Asynchronous serial receiver for 7E1 frames: 1 start bit, 7 data bits LSB first, 1 parity bit, 1 stop bit.
- It is the receive end of the sonar serial link and pairs with the 7E1 transmitter already in the design.
- It oversamples the line with the system clock, samples each bit at mid-bit, checks parity and stop, and presents the character through a hold/clear handshake.

---
 rtl/rx_serial_pkg.sv | 27 ++
 rtl/rx_serial_7e1_uc.sv | 65 ++++++
 rtl/rx_serial_7e1.sv | 154 +++++++++++++++
 tb/tb_rx_serial_7e1.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7E1 serial receiver: FSM encoding, frame sizes
// and the baud-counter width helper.
package rx_serial_pkg;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        CONFIRMA = 2'd1,
        RECEBE   = 2'd2,
        ARMAZENA = 2'd3
    } estado_t;

    localparam int unsigned NUM_DADOS       = 7;
    localparam int unsigned NUM_BITS_QUADRO = 9;

    function automatic int unsigned clog2(input int unsigned valor);
        int unsigned largura;
        int unsigned resto;
        largura = 0;
        resto   = valor - 1;
        while (resto > 0) begin
            largura++;
            resto = resto >> 1;
        end
        return largura;
    endfunction

endpackage

// File: rtl/rx_serial_7e1_uc.sv
// Control unit of the 7E1 receiver: start detection/confirmation, bit
// sequencing and the one-clock store step.
module rx_serial_7e1_uc
    import rx_serial_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rx_s,
    input  logic bit_rx,
    input  logic fim_meio,
    input  logic fim_bit,
    input  logic ultimo_bit,
    output logic zera_baud,
    output logic conta_baud,
    output logic zera_bit,
    output logic amostra,
    output logic armazena
);

    estado_t estado_q, estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado_q <= ESPERA;
        else        estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            ESPERA:   if (!rx_s) estado_d = CONFIRMA;
            CONFIRMA: if (fim_meio) estado_d = bit_rx ? ESPERA : RECEBE;
            RECEBE:   if (fim_bit && ultimo_bit) estado_d = ARMAZENA;
            ARMAZENA: estado_d = ESPERA;
            default:  estado_d = ESPERA;
        endcase
    end

    always_comb begin
        zera_baud  = 1'b0;
        conta_baud = 1'b0;
        zera_bit   = 1'b0;
        amostra    = 1'b0;
        armazena   = 1'b0;
        unique case (estado_q)
            ESPERA: zera_baud = 1'b1;
            CONFIRMA: begin
                conta_baud = 1'b1;
                if (fim_meio && !bit_rx) begin
                    zera_baud = 1'b1;
                    zera_bit  = 1'b1;
                end
            end
            RECEBE: begin
                conta_baud = 1'b1;
                if (fim_bit) begin
                    zera_baud = 1'b1;
                    amostra   = 1'b1;
                end
            end
            ARMAZENA: armazena = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous receiver (start, 7 data LSB first, parity, stop) with
// hold/clear handshake. Define RX_VOTO_MAIORIA_EN for 3-sample majority voting.
module rx_serial_7e1
    import rx_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter bit          PARIDADE_IMPAR = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       overrun
);

    localparam int unsigned        W_BAUD  = clog2(CLKS_PER_BIT);
    localparam logic [W_BAUD-1:0] MEIO_TC = W_BAUD'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W_BAUD-1:0] BIT_TC  = W_BAUD'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        IDX_PAR = 4'(NUM_DADOS);
    localparam logic [3:0]        ULTIMO  = 4'(NUM_BITS_QUADRO - 1);

    logic sync_q, sync_d, rx_s_q, rx_s_d;
    logic [W_BAUD-1:0] cnt_baud_q, cnt_baud_d;
    logic [3:0] cnt_bit_q, cnt_bit_d;
    logic [NUM_DADOS-1:0] desloc_q, desloc_d, dados_q, dados_d;
    logic par_q, par_d, stop_q, stop_d;
    logic pronto_q, pronto_d, tem_dado_q, tem_dado_d;
    logic erro_par_q, erro_par_d, erro_stop_q, erro_stop_d, overrun_q, overrun_d;
    logic bit_rx;
    logic zera_baud, conta_baud, zera_bit, amostra, armazena;

`ifdef RX_VOTO_MAIORIA_EN
    // Window is the last three rx_s values, so the voted bit lands on the same edge as a single sample would.
    logic h1_q, h1_d, h2_q, h2_d;

    always_comb begin
        h1_d   = rx_s_q;
        h2_d   = h1_q;
        bit_rx = (rx_s_q & h1_q) | (rx_s_q & h2_q) | (h1_q & h2_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h1_q <= 1'b1;
            h2_q <= 1'b1;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`else
    assign bit_rx = rx_s_q;
`endif

    rx_serial_7e1_uc u_uc (
        .clock      (clock),
        .reset      (reset),
        .rx_s       (rx_s_q),
        .bit_rx     (bit_rx),
        .fim_meio   (cnt_baud_q == MEIO_TC),
        .fim_bit    (cnt_baud_q == BIT_TC),
        .ultimo_bit (cnt_bit_q == ULTIMO),
        .zera_baud  (zera_baud),
        .conta_baud (conta_baud),
        .zera_bit   (zera_bit),
        .amostra    (amostra),
        .armazena   (armazena)
    );

    always_comb begin
        sync_d      = entrada_serial;
        rx_s_d      = sync_q;
        cnt_baud_d  = cnt_baud_q;
        cnt_bit_d   = cnt_bit_q;
        desloc_d    = desloc_q;
        par_d       = par_q;
        stop_d      = stop_q;
        dados_d     = dados_q;
        pronto_d    = armazena;
        tem_dado_d  = tem_dado_q;
        erro_par_d  = erro_par_q;
        erro_stop_d = erro_stop_q;
        overrun_d   = overrun_q;

        if (zera_baud)       cnt_baud_d = '0;
        else if (conta_baud) cnt_baud_d = cnt_baud_q + 1'b1;

        if (zera_bit)     cnt_bit_d = '0;
        else if (amostra) cnt_bit_d = cnt_bit_q + 1'b1;

        if (amostra) begin
            if (cnt_bit_q < IDX_PAR)       desloc_d = {bit_rx, desloc_q[NUM_DADOS-1:1]};
            else if (cnt_bit_q == IDX_PAR) par_d    = bit_rx;
            else                           stop_d   = bit_rx;
        end

        // A store in the same clock as limpa wins; overrun sees the pre-limpa tem_dado.
        if (armazena) begin
            dados_d     = desloc_q;
            erro_par_d  = ((^desloc_q) ^ par_q) != PARIDADE_IMPAR;
            erro_stop_d = ~stop_q;
            overrun_d   = overrun_q | tem_dado_q;
            tem_dado_d  = 1'b1;
        end else if (limpa) begin
            tem_dado_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_baud_q  <= '0;
            cnt_bit_q   <= '0;
            desloc_q    <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            dados_q     <= '0;
            pronto_q    <= 1'b0;
            tem_dado_q  <= 1'b0;
            erro_par_q  <= 1'b0;
            erro_stop_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_s_q      <= rx_s_d;
            cnt_baud_q  <= cnt_baud_d;
            cnt_bit_q   <= cnt_bit_d;
            desloc_q    <= desloc_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            dados_q     <= dados_d;
            pronto_q    <= pronto_d;
            tem_dado_q  <= tem_dado_d;
            erro_par_q  <= erro_par_d;
            erro_stop_q <= erro_stop_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dados_ascii   = dados_q;
    assign pronto        = pronto_q;
    assign tem_dado      = tem_dado_q;
    assign erro_paridade = erro_par_q;
    assign erro_stop     = erro_stop_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1 at 8 clocks per bit, even parity.
module tb_rx_serial_7e1;

    localparam int unsigned C = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       entrada_serial = 1'b1;
    logic       limpa = 1'b0;
    logic [6:0] dados_ascii;
    logic       pronto, tem_dado, erro_paridade, erro_stop, overrun;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_pronto = 0;
    int unsigned base;
    logic [9:0] quadro;

    rx_serial_7e1 #(.CLKS_PER_BIT(C), .PARIDADE_IMPAR(1'b0)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .limpa          (limpa),
        .dados_ascii    (dados_ascii),
        .pronto         (pronto),
        .tem_dado       (tem_dado),
        .erro_paridade  (erro_paridade),
        .erro_stop      (erro_stop),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (pronto === 1'b1) n_pronto++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Line is left at the stop-bit value; glitch inverts one clock of bit gbit.
    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                              input int unsigned gbit, input int unsigned goff);
        logic [9:0] fr;
        fr = {stp, par, d, 1'b0};
        for (int unsigned b = 0; b < 10; b++) begin
            for (int unsigned j = 0; j < C; j++) begin
                entrada_serial = (b == gbit && j == goff) ? ~fr[b] : fr[b];
                tick(1);
            end
        end
    endtask

    task automatic pulse_limpa();
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        tick(3);
        chk("rst_dados",    32'(dados_ascii),   32'h0);
        chk("rst_pronto",   32'(pronto),        32'h0);
        chk("rst_tem_dado", 32'(tem_dado),      32'h0);
        chk("rst_erro_par", 32'(erro_paridade), 32'h0);
        chk("rst_erro_stp", 32'(erro_stop),     32'h0);
        chk("rst_overrun",  32'(overrun),       32'h0);
        reset = 1'b1;
        tick(20);

        base = n_pronto;
        send_frame(7'h41, 1'b0, 1'b1, 99, 0);
        entrada_serial = 1'b1;
        tick(2 * C);
        chk("a41_dados",    32'(dados_ascii),   32'h41);
        chk("a41_pronto",   n_pronto - base,    32'd1);
        chk("a41_tem_dado", 32'(tem_dado),      32'h1);
        chk("a41_erro_par", 32'(erro_paridade), 32'h0);
        chk("a41_erro_stp", 32'(erro_stop),     32'h0);
        chk("a41_overrun",  32'(overrun),       32'h0);
        pulse_limpa();
        chk("limpa_tem_dado", 32'(tem_dado), 32'h0);

        base = n_pronto;
        send_frame(7'h41, 1'b1, 1'b1, 99, 0);
        entrada_serial = 1'b1;
        tick(2 * C);
        chk("par_dados",    32'(dados_ascii),   32'h41);
        chk("par_erro_par", 32'(erro_paridade), 32'h1);
        chk("par_pronto",   n_pronto - base,    32'd1);
        pulse_limpa();

        // Stop bit low, line kept low 3 more bit times, then released.
        base = n_pronto;
        send_frame(7'h55, 1'b0, 1'b0, 99, 0);
        tick(3 * C);
        chk("stp_dados",    32'(dados_ascii),   32'h55);
        chk("stp_erro_stp", 32'(erro_stop),     32'h1);
        chk("stp_erro_par", 32'(erro_paridade), 32'h0);
        chk("stp_pronto",   n_pronto - base,    32'd1);
        entrada_serial = 1'b1;
        tick(10 * C);
        chk("brk_pronto",   n_pronto - base,    32'd2);
        chk("brk_dados",    32'(dados_ascii),   32'h7C);
        chk("brk_erro_stp", 32'(erro_stop),     32'h0);
        chk("brk_overrun",  32'(overrun),       32'h1);
        pulse_limpa();
        chk("brk_limpa_ovr", 32'(overrun), 32'h0);

        base = n_pronto;
        entrada_serial = 1'b0;
        tick(2);
        entrada_serial = 1'b1;
        tick(5 * C);
        chk("glitch_pronto",   n_pronto - base,  32'd0);
        chk("glitch_tem_dado", 32'(tem_dado),    32'h0);

        base = n_pronto;
        send_frame(7'h31, 1'b1, 1'b1, 99, 0);
        send_frame(7'h32, 1'b1, 1'b1, 99, 0);
        entrada_serial = 1'b1;
        tick(2 * C);
        chk("b2b_pronto",   n_pronto - base,    32'd2);
        chk("b2b_dados",    32'(dados_ascii),   32'h32);
        chk("b2b_overrun",  32'(overrun),       32'h1);
        chk("b2b_tem_dado", 32'(tem_dado),      32'h1);
        chk("b2b_erro_par", 32'(erro_paridade), 32'h0);
        pulse_limpa();
        chk("b2b_limpa_tem", 32'(tem_dado), 32'h0);
        chk("b2b_limpa_ovr", 32'(overrun),  32'h0);

        // Frame cut off halfway through data bit 4.
        pulse_limpa();
        send_frame(7'h2B, 1'b0, 1'b1, 99, 0);
        entrada_serial = 1'b1;
        tick(2 * C);
        base = n_pronto;
        quadro = {1'b1, 1'b1, 7'h2A, 1'b0};
        for (int unsigned k = 0; k < 5 * C + C / 2; k++) begin
            entrada_serial = quadro[k / C];
            tick(1);
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_dados",    32'(dados_ascii),   32'h0);
        chk("mid_rst_tem_dado", 32'(tem_dado),      32'h0);
        chk("mid_rst_erro_par", 32'(erro_paridade), 32'h0);
        chk("mid_rst_erro_stp", 32'(erro_stop),     32'h0);
        chk("mid_rst_overrun",  32'(overrun),       32'h0);
        chk("mid_rst_pronto",   32'(pronto),        32'h0);
        entrada_serial = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(20);
        chk("mid_rst_no_pronto", n_pronto - base, 32'd0);
        send_frame(7'h7F, 1'b1, 1'b1, 99, 0);
        entrada_serial = 1'b1;
        tick(2 * C);
        chk("f7f_dados",    32'(dados_ascii),   32'h7F);
        chk("f7f_pronto",   n_pronto - base,    32'd1);
        chk("f7f_erro_par", 32'(erro_paridade), 32'h0);
        chk("f7f_erro_stp", 32'(erro_stop),     32'h0);
        chk("f7f_tem_dado", 32'(tem_dado),      32'h1);

`ifdef RX_VOTO_MAIORIA_EN
        pulse_limpa();
        base = n_pronto;
        send_frame(7'h41, 1'b0, 1'b1, 1, 4);
        entrada_serial = 1'b1;
        tick(2 * C);
        chk("voto_dados",    32'(dados_ascii),   32'h41);
        chk("voto_erro_par", 32'(erro_paridade), 32'h0);
        chk("voto_pronto",   n_pronto - base,    32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
